// File: rtl/tblock_dispatcher_pkg.sv
// tblock_dispatcher_pkg: shared sizes, typedefs and the dispatcher FSM state
// encoding for the thread-block dispatcher slice.
package tblock_dispatcher_pkg;

  localparam int NUM_CLUSTERS    = 2;
  localparam int PC_WIDTH        = 16;
  localparam int ADDR_WIDTH      = 32;
  localparam int TBLOCK_IDX_BITS = 8;
  localparam int TBLOCK_ID_BITS  = 3;
  localparam int NUM_IDS         = 1 << TBLOCK_ID_BITS;
  localparam int CLUSTER_IDX_W   = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;

  typedef logic [PC_WIDTH-1:0]        pc_t;
  typedef logic [ADDR_WIDTH-1:0]      addr_t;
  typedef logic [TBLOCK_IDX_BITS-1:0] tblock_idx_t;
  typedef logic [TBLOCK_ID_BITS-1:0]  tblock_id_t;
  typedef logic [TBLOCK_IDX_BITS:0]   tblock_cnt_t;
  typedef logic [TBLOCK_ID_BITS:0]    outstanding_t;
  typedef logic [CLUSTER_IDX_W-1:0]   cluster_idx_t;

  // Largest kernel size; bigger launch requests are clamped to this.
  localparam tblock_cnt_t MAX_TBLOCKS = tblock_cnt_t'(1 << TBLOCK_IDX_BITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_DRAIN,
    ST_DONE
  } dispatch_state_e;

  // Round-robin successor of a cluster index.
  function automatic cluster_idx_t rr_next(input cluster_idx_t idx);
    if (idx == cluster_idx_t'(NUM_CLUSTERS - 1)) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/tblock_dispatcher_if.sv
// tblock_dispatcher_if: launch, kernel-done, allocation and completion
// signals between a host/cluster side (master) and the dispatcher (slave).
// Handshakes: a transfer happens in any cycle where valid and ready are both
// high; valid never waits on ready, and allocate_warp_o is a ready-less
// single-cycle strobe.
interface tblock_dispatcher_if;
  import tblock_dispatcher_pkg::*;

  logic                                     launch_valid_i;
  logic                                     launch_ready_o;
  pc_t                                      launch_pc_i;
  addr_t                                    launch_dp_addr_i;
  tblock_cnt_t                              launch_num_tblocks_i;
  logic                                     kernel_done_o;
  logic                                     kernel_done_ready_i;
  logic [NUM_CLUSTERS-1:0]                  warp_free_i;
  logic [NUM_CLUSTERS-1:0]                  allocate_warp_o;
  pc_t                                      allocate_pc_o;
  addr_t                                    allocate_dp_addr_o;
  tblock_idx_t                              allocate_tblock_idx_o;
  tblock_id_t                               allocate_tblock_id_o;
  logic [NUM_CLUSTERS-1:0]                  tblock_done_i;
  logic [NUM_CLUSTERS*TBLOCK_ID_BITS-1:0]   tblock_done_id_i;
  logic [NUM_CLUSTERS-1:0]                  tblock_done_ready_o;

  modport slave (
    input  launch_valid_i, launch_pc_i, launch_dp_addr_i, launch_num_tblocks_i,
    input  kernel_done_ready_i, warp_free_i, tblock_done_i, tblock_done_id_i,
    output launch_ready_o, kernel_done_o, allocate_warp_o, allocate_pc_o,
    output allocate_dp_addr_o, allocate_tblock_idx_o, allocate_tblock_id_o,
    output tblock_done_ready_o
  );

  modport master (
    output launch_valid_i, launch_pc_i, launch_dp_addr_i, launch_num_tblocks_i,
    output kernel_done_ready_i, warp_free_i, tblock_done_i, tblock_done_id_i,
    input  launch_ready_o, kernel_done_o, allocate_warp_o, allocate_pc_o,
    input  allocate_dp_addr_o, allocate_tblock_idx_o, allocate_tblock_id_o,
    input  tblock_done_ready_o
  );

endinterface

// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin arbiter over NumInp valid/ready streams.
// Ports: inp_valid_i/inp_ready_o/inp_data_i (packed, input 0 in LSBs),
// oup_valid_o/oup_ready_i/oup_data_o. The search starts at the input after
// the previous winner; ready is one-hot to the winner in the same cycle.
module stream_arbiter #(
  parameter int NumInp    = 2,
  parameter int DataWidth = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumInp-1:0]             inp_valid_i,
  output logic [NumInp-1:0]             inp_ready_o,
  input  logic [NumInp*DataWidth-1:0]   inp_data_i,
  output logic                          oup_valid_o,
  input  logic                          oup_ready_i,
  output logic [DataWidth-1:0]          oup_data_o
);

  localparam int IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;

  logic [IdxW-1:0] rr_q;
  logic [IdxW-1:0] cand;
  logic [IdxW-1:0] win;

  always_comb begin
    oup_valid_o = 1'b0;
    win         = rr_q;
    cand        = '0;
    for (int i = 0; i < NumInp; i++) begin
      cand = IdxW'((int'(rr_q) + i) % NumInp);
      if (!oup_valid_o && inp_valid_i[cand]) begin
        oup_valid_o = 1'b1;
        win         = cand;
      end
    end
  end

  always_comb begin
    inp_ready_o = '0;
    if (oup_valid_o && oup_ready_i) inp_ready_o[win] = 1'b1;
  end

  assign oup_data_o = inp_data_i[win*DataWidth +: DataWidth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (oup_valid_o && oup_ready_i) begin
      rr_q <= (win == IdxW'(NumInp - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/tblock_id_pool.sv
// tblock_id_pool: bitmap of in-flight thread-block ids.
// Ports: alloc_i claims alloc_id_o (lowest free id); full_o when every id is
// busy; free_i/free_id_i release an id; free_stale_o flags a release of an
// id that is not busy (the pool is left unchanged in that case).
module tblock_id_pool
  import tblock_dispatcher_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       alloc_i,
  output tblock_id_t alloc_id_o,
  output logic       full_o,
  input  logic       free_i,
  input  tblock_id_t free_id_i,
  output logic       free_stale_o
);

  logic [NUM_IDS-1:0] busy_q;
  logic [NUM_IDS-1:0] busy_d;

  // Descending scan so the last hit is the lowest free index.
  always_comb begin
    alloc_id_o = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_id_o = tblock_id_t'(i);
    end
  end

  assign full_o       = &busy_q;
  assign free_stale_o = free_i & ~busy_q[free_id_i];

  // Alloc picks a free id and a valid free names a busy one, so they never
  // collide; the freed id only shows as free from the next cycle on.
  always_comb begin
    busy_d = busy_q;
    if (alloc_i && !full_o)       busy_d[alloc_id_o] = 1'b1;
    if (free_i && !free_stale_o)  busy_d[free_id_i]  = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && free_i) begin
      assert (busy_q[free_id_i])
        else $warning("tblock_id_pool: completion for id %0d that is not in flight", free_id_i);
    end
  end

endmodule

// File: rtl/tblock_dispatcher.sv
// tblock_dispatcher: accepts one kernel launch, issues its thread blocks one
// per cycle to free clusters (round-robin), tags each with a unique in-flight
// id, collects completions and reports kernel done.
// Ports: clk_i, rst_i (sync, active-high); bus (slave side of
// tblock_dispatcher_if); dbg_state_o / dbg_outstanding_o expose the FSM state
// and in-flight block count.
module tblock_dispatcher
  import tblock_dispatcher_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  tblock_dispatcher_if.slave   bus,
  output dispatch_state_e      dbg_state_o,
  output outstanding_t         dbg_outstanding_o
);

  dispatch_state_e state_q, state_d;
  pc_t             pc_q;
  addr_t           dp_q;
  tblock_cnt_t     num_q;
  tblock_cnt_t     dispatched_q;
  outstanding_t    outstanding_q;
  cluster_idx_t    rr_alloc_q;

  logic            launch_fire;
  tblock_cnt_t     launch_num;
  logic            alloc_fire;
  logic            pool_full;
  tblock_id_t      free_id;
  cluster_idx_t    alloc_target;
  cluster_idx_t    cand;
  logic            done_valid;
  tblock_id_t      done_id;
  logic            done_stale;
  logic            retire;

  assign launch_fire = bus.launch_valid_i & bus.launch_ready_o;
  assign launch_num  = (bus.launch_num_tblocks_i > MAX_TBLOCKS) ? MAX_TBLOCKS
                                                                : bus.launch_num_tblocks_i;

  // First free cluster at or after the round-robin pointer.
  always_comb begin
    alloc_target = rr_alloc_q;
    cand         = '0;
    for (int i = NUM_CLUSTERS - 1; i >= 0; i--) begin
      cand = cluster_idx_t'((int'(rr_alloc_q) + i) % NUM_CLUSTERS);
      if (bus.warp_free_i[cand]) alloc_target = cand;
    end
  end

  assign alloc_fire = (state_q == ST_DISPATCH) && (dispatched_q < num_q) &&
                      !pool_full && (|bus.warp_free_i);

  always_comb begin
    bus.allocate_warp_o = '0;
    if (alloc_fire) bus.allocate_warp_o[alloc_target] = 1'b1;
  end

  assign bus.allocate_pc_o         = pc_q;
  assign bus.allocate_dp_addr_o    = dp_q;
  assign bus.allocate_tblock_idx_o = dispatched_q[TBLOCK_IDX_BITS-1:0];
  assign bus.allocate_tblock_id_o  = free_id;

  // The dispatcher always takes a completion, so the arbiter output is
  // never back-pressured.
  stream_arbiter #(
    .NumInp    (NUM_CLUSTERS),
    .DataWidth (TBLOCK_ID_BITS)
  ) u_done_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inp_valid_i (bus.tblock_done_i),
    .inp_ready_o (bus.tblock_done_ready_o),
    .inp_data_i  (bus.tblock_done_id_i),
    .oup_valid_o (done_valid),
    .oup_ready_i (1'b1),
    .oup_data_o  (done_id)
  );

  tblock_id_pool u_id_pool (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alloc_i      (alloc_fire),
    .alloc_id_o   (free_id),
    .full_o       (pool_full),
    .free_i       (done_valid),
    .free_id_i    (done_id),
    .free_stale_o (done_stale)
  );

  assign retire = done_valid & ~done_stale;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (launch_fire) state_d = (launch_num == '0) ? ST_DONE : ST_DISPATCH;
      ST_DISPATCH: if (alloc_fire && (dispatched_q + tblock_cnt_t'(1)) == num_q) state_d = ST_DRAIN;
      ST_DRAIN:    if (outstanding_q == '0) state_d = ST_DONE;
      ST_DONE:     if (bus.kernel_done_ready_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign bus.launch_ready_o = (state_q == ST_IDLE);
  assign bus.kernel_done_o  = (state_q == ST_DONE);
  assign dbg_state_o        = state_q;
  assign dbg_outstanding_o  = outstanding_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      dp_q          <= '0;
      num_q         <= '0;
      dispatched_q  <= '0;
      outstanding_q <= '0;
      rr_alloc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (launch_fire) begin
        pc_q         <= bus.launch_pc_i;
        dp_q         <= bus.launch_dp_addr_i;
        num_q        <= launch_num;
        dispatched_q <= '0;
      end
      if (alloc_fire) begin
        dispatched_q <= dispatched_q + tblock_cnt_t'(1);
        rr_alloc_q   <= rr_next(alloc_target);
      end
      case ({alloc_fire, retire})
        2'b10:   outstanding_q <= outstanding_q + outstanding_t'(1);
        2'b01:   outstanding_q <= outstanding_q - outstanding_t'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

endmodule

// File: tb/tb_tblock_dispatcher.sv
// tb_tblock_dispatcher: self-checking bench for tblock_dispatcher. Expected
// allocations are queued when a scenario is set up and popped by a monitor
// whenever the DUT strobes allocate_warp_o.
module tb_tblock_dispatcher;
  import tblock_dispatcher_pkg::*;

  localparam int EW = NUM_CLUSTERS + TBLOCK_IDX_BITS + TBLOCK_ID_BITS;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  tblock_dispatcher_if bus();
  dispatch_state_e dbg_state;
  outstanding_t    dbg_outstanding;

  tblock_dispatcher dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .bus               (bus),
    .dbg_state_o       (dbg_state),
    .dbg_outstanding_o (dbg_outstanding)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;
  int   n_checks = 0;
  int   n_fail   = 0;
  pc_t  exp_pc   = '0;
  addr_t exp_dp  = '0;
  int   exp_alloc_rr = 0;
  logic mon_en   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (mon_en && !rst_i && bus.allocate_warp_o != '0) begin
      if (exp_q.size() == 0) begin
        check("alloc_unexpected",
              {bus.allocate_warp_o, bus.allocate_tblock_idx_o, bus.allocate_tblock_id_o}, '0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("alloc", {bus.allocate_warp_o, bus.allocate_tblock_idx_o,
                        bus.allocate_tblock_id_o}, mon_exp);
        check("alloc_pc", bus.allocate_pc_o, exp_pc);
        check("alloc_dp", bus.allocate_dp_addr_o, exp_dp);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_alloc(input int cluster, input int idx, input int id);
    logic [NUM_CLUSTERS-1:0] w;
    tblock_idx_t x;
    tblock_id_t  d;
    w = '0;
    w[cluster] = 1'b1;
    x = tblock_idx_t'(idx);
    d = tblock_id_t'(id);
    exp_q.push_back({w, x, d});
    exp_alloc_rr = (cluster + 1) % NUM_CLUSTERS;
  endtask

  task automatic launch(input pc_t pc, input addr_t dp, input tblock_cnt_t num);
    exp_pc = pc;
    exp_dp = dp;
    bus.launch_valid_i       = 1'b1;
    bus.launch_pc_i          = pc;
    bus.launch_dp_addr_i     = dp;
    bus.launch_num_tblocks_i = num;
    check("launch_ready", bus.launch_ready_o, 1'b1);
    tick();
    bus.launch_valid_i = 1'b0;
  endtask

  task automatic wait_allocs(input string tag, input int budget, output int cycles);
    for (cycles = 0; cycles < budget && exp_q.size() != 0; cycles++) tick();
    check(tag, exp_q.size(), 0);
  endtask

  task automatic set_done(input int cluster, input int id);
    bus.tblock_done_i[cluster] = 1'b1;
    bus.tblock_done_id_i[cluster*TBLOCK_ID_BITS +: TBLOCK_ID_BITS] = tblock_id_t'(id);
  endtask

  task automatic complete(input int cluster, input int id);
    logic [NUM_CLUSTERS-1:0] w;
    w = '0;
    w[cluster] = 1'b1;
    set_done(cluster, id);
    @(negedge clk_i);
    check("done_ready", bus.tblock_done_ready_o, w);
    tick();
    bus.tblock_done_i = '0;
  endtask

  task automatic wait_done(input string tag, output int cycles);
    for (cycles = 0; cycles < 20 && !bus.kernel_done_o; cycles++) tick();
    check(tag, bus.kernel_done_o, 1'b1);
  endtask

  task automatic ack_done();
    bus.kernel_done_ready_i = 1'b1;
    tick();
    bus.kernel_done_ready_i = 1'b0;
    check("ack_launch_ready", bus.launch_ready_o, 1'b1);
    check("ack_kernel_done", bus.kernel_done_o, 1'b0);
  endtask

  task automatic check_reset_values();
    check("rst_launch_ready", bus.launch_ready_o, 1'b1);
    check("rst_kernel_done", bus.kernel_done_o, 1'b0);
    check("rst_alloc_warp", bus.allocate_warp_o, '0);
    check("rst_done_ready", bus.tblock_done_ready_o, '0);
    check("rst_alloc_pc", bus.allocate_pc_o, '0);
    check("rst_alloc_dp", bus.allocate_dp_addr_o, '0);
    check("rst_alloc_idx", bus.allocate_tblock_idx_o, '0);
    check("rst_alloc_id", bus.allocate_tblock_id_o, '0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_outstanding", dbg_outstanding, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w;
    int exp_arb_rr;
    int q0[$];
    int q1[$];
    logic [NUM_CLUSTERS-1:0] exp_ready;
    int ids_t3[8] = '{1, 2, 3, 4, 6, 7, 0, 5};

    bus.launch_valid_i       = 1'b0;
    bus.launch_pc_i          = '0;
    bus.launch_dp_addr_i     = '0;
    bus.launch_num_tblocks_i = '0;
    bus.kernel_done_ready_i  = 1'b0;
    bus.warp_free_i          = '0;
    bus.tblock_done_i        = '0;
    bus.tblock_done_id_i     = '0;
    exp_arb_rr               = 0;

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check_reset_values();
    mon_en = 1'b1;

    // 1: N=3, both clusters free; then complete 2,0,1
    bus.warp_free_i = '1;
    push_alloc(0, 0, 0);
    push_alloc(1, 1, 1);
    push_alloc(0, 2, 2);
    launch(16'h0040, 32'h0000_1000, 3);
    wait_allocs("t1_allocs", 20, n);
    check("t1_consecutive", n, 3);
    bus.warp_free_i = '0;
    check("t1_state_drain", dbg_state, ST_DRAIN);
    check("t1_outstanding", dbg_outstanding, 3);
    complete(0, 2);
    complete(1, 0);
    check("t1_not_done_early", bus.kernel_done_o, 1'b0);
    complete(0, 1);
    exp_arb_rr = 1;
    wait_done("t1_kernel_done", n);
    check("t1_done_latency", n, 1);
    ack_done();

    // 2: N=0 finishes immediately with no allocation
    bus.warp_free_i = '1;
    launch(16'h0010, 32'h0000_0100, 0);
    check("t2_done_next_cycle", bus.kernel_done_o, 1'b1);
    repeat (3) tick();
    check("t2_still_done", bus.kernel_done_o, 1'b1);
    ack_done();

    // 3: N=10 with completions withheld: 8 allocations, then id reuse
    for (int i = 0; i < 8; i++) push_alloc(exp_alloc_rr, i, i);
    launch(16'h0080, 32'h0000_2000, 10);
    wait_allocs("t3_allocs", 30, n);
    check("t3_alloc_cycles", n, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("t3_stall", bus.allocate_warp_o, '0);
      tick();
    end
    check("t3_outstanding_full", dbg_outstanding, 8);
    check("t3_state_dispatch", dbg_state, ST_DISPATCH);
    set_done(0, 5);
    @(negedge clk_i);
    check("t3_done_ready", bus.tblock_done_ready_o, 2'b01);
    check("t3_no_same_cycle_reuse", bus.allocate_warp_o, '0);
    push_alloc(exp_alloc_rr, 8, 5);
    tick();
    bus.tblock_done_i = '0;
    wait_allocs("t3_reuse_id5", 5, n);
    check("t3_reuse_latency", n, 1);
    complete(0, 0);
    push_alloc(exp_alloc_rr, 9, 0);
    wait_allocs("t3_reuse_id0", 5, n);
    check("t3_state_drain", dbg_state, ST_DRAIN);
    bus.warp_free_i = '0;
    foreach (ids_t3[i]) complete(1, ids_t3[i]);
    exp_arb_rr = 0;
    wait_done("t3_kernel_done", n);
    ack_done();

    // 4a: both clusters complete every cycle -> ready alternates
    bus.warp_free_i = '1;
    for (int i = 0; i < 4; i++) push_alloc(exp_alloc_rr, i, i);
    launch(16'h0100, 32'h0000_3000, 4);
    wait_allocs("t4_allocs", 20, n);
    bus.warp_free_i = '0;
    q0 = '{0, 2};
    q1 = '{1, 3};
    for (int k = 0; k < 8 && (q0.size() != 0 || q1.size() != 0); k++) begin
      bus.tblock_done_i = '0;
      if (q0.size() != 0) set_done(0, q0[0]);
      if (q1.size() != 0) set_done(1, q1[0]);
      if (q0.size() != 0 && q1.size() != 0) w = exp_arb_rr;
      else w = (q0.size() != 0) ? 0 : 1;
      exp_ready = '0;
      exp_ready[w] = 1'b1;
      @(negedge clk_i);
      check("t4_rr_ready", bus.tblock_done_ready_o, exp_ready);
      if (w == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
      exp_arb_rr = (w + 1) % NUM_CLUSTERS;
      tick();
    end
    bus.tblock_done_i = '0;
    wait_done("t4_kernel_done", n);
    ack_done();

    // 4b: allocate and complete in the same cycle
    bus.warp_free_i = '0;
    launch(16'h0140, 32'h0000_4000, 2);
    push_alloc(0, 0, 0);
    bus.warp_free_i = 2'b01;
    tick();
    bus.warp_free_i = '0;
    check("t4b_outstanding_before", dbg_outstanding, 1);
    push_alloc(1, 1, 1);
    bus.warp_free_i = 2'b10;
    set_done(0, 0);
    @(negedge clk_i);
    check("t4b_done_ready", bus.tblock_done_ready_o, 2'b01);
    tick();
    bus.tblock_done_i = '0;
    bus.warp_free_i   = '0;
    check("t4b_outstanding_net", dbg_outstanding, 1);
    check("t4b_state_drain", dbg_state, ST_DRAIN);
    check("t4b_exp_drained", exp_q.size(), 0);
    complete(1, 1);
    wait_done("t4b_kernel_done", n);
    ack_done();

    // 5: no free warp for 20 cycles, then only cluster 1
    bus.warp_free_i = '0;
    launch(16'h0180, 32'h0000_5000, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      check("t5_no_alloc", bus.allocate_warp_o, '0);
      tick();
    end
    push_alloc(1, 0, 0);
    bus.warp_free_i = 2'b10;
    wait_allocs("t5_alloc_c1", 5, n);
    bus.warp_free_i = '1;
    tick();
    check("t5_state_drain", dbg_state, ST_DRAIN);
    check("t5_outstanding", dbg_outstanding, 1);

    // 6: reset mid-DRAIN, then a stale completion
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_alloc_rr = 0;
    check_reset_values();
    set_done(0, 0);
    @(negedge clk_i);
    check("t6_stale_accepted", bus.tblock_done_ready_o, 2'b01);
    tick();
    bus.tblock_done_i = '0;
    check("t6_outstanding_unchanged", dbg_outstanding, 0);
    check("t6_state_idle", dbg_state, ST_IDLE);
    bus.warp_free_i = 2'b01;
    push_alloc(0, 0, 0);
    launch(16'h01c0, 32'h0000_6000, 1);
    wait_allocs("t6_relaunch_alloc", 5, n);
    bus.warp_free_i = '0;
    complete(0, 0);
    wait_done("t6_kernel_done", n);
    ack_done();

    repeat (2) tick();
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
